// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one main-memory line port between the I-cache and D-cache miss paths
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   i_read/i_addr            I-cache line read request (held until i_ready)
//   i_rdata/i_ready          I-cache line data and one-cycle completion pulse
//   d_read/d_write/d_addr    D-cache line read / write-back request (held until d_ready)
//   d_wdata                  D-cache write-back line data
//   d_rdata/d_ready          D-cache line data and one-cycle completion pulse
//   mem_read/mem_write       memory command, held until mem_ready
//   mem_addr/mem_wdata       memory line address and write data
//   mem_rdata/mem_ready      memory read data and one-cycle completion pulse
//   busy                     high whenever the FSM is not in IDLE
module mem_port_arbiter #(
    parameter int ADDR_W       = 28,
    parameter int DATA_W       = 128,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ready,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2,
        RESP    = 2'd3
    } state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t              state_q, state_d;
    logic [3:0]          starve_cnt_q, starve_cnt_d;
    logic                mem_read_q, mem_read_d;
    logic                mem_write_q, mem_write_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0]   i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
    logic                i_ready_q, i_ready_d;
    logic                d_ready_q, d_ready_d;
    logic                busy_q, busy_d;

    logic d_req;
    logic i_starved;

    assign d_req     = d_read | d_write;
    // The I side only overrides D priority once it has waited out the full limit.
    assign i_starved = i_read && (starve_cnt_q == LIMIT);

    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        mem_read_d   = mem_read_q;
        mem_write_d  = mem_write_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        i_rdata_d    = i_rdata_q;
        d_rdata_d    = d_rdata_q;
        i_ready_d    = 1'b0;
        d_ready_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (d_req && !i_starved) begin
                    state_d    = SERVE_D;
                    mem_addr_d = d_addr;
                    // A write-back takes precedence if both request lines are raised.
                    if (d_write) begin
                        mem_write_d = 1'b1;
                        mem_wdata_d = d_wdata;
                    end else begin
                        mem_read_d = 1'b1;
                    end
                    if (i_read) begin
                        starve_cnt_d = (starve_cnt_q >= LIMIT) ? LIMIT : starve_cnt_q + 4'd1;
                    end else begin
                        starve_cnt_d = 4'd0;
                    end
                end else if (i_read) begin
                    state_d      = SERVE_I;
                    mem_read_d   = 1'b1;
                    mem_addr_d   = i_addr;
                    starve_cnt_d = 4'd0;
                end
            end
            SERVE_I: begin
                if (mem_ready) begin
                    mem_read_d = 1'b0;
                    i_rdata_d  = mem_rdata;
                    i_ready_d  = 1'b1;
                    state_d    = RESP;
                end
            end
            SERVE_D: begin
                if (mem_ready) begin
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    // Write-backs return no data, so the last read line stays visible.
                    if (mem_read_q) begin
                        d_rdata_d = mem_rdata;
                    end
                    d_ready_d = 1'b1;
                    state_d   = RESP;
                end
            end
            // The served cache is still dropping its request here, so nothing is sampled.
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            starve_cnt_q <= 4'd0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            i_rdata_q    <= '0;
            d_rdata_q    <= '0;
            i_ready_q    <= 1'b0;
            d_ready_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            i_rdata_q    <= i_rdata_d;
            d_rdata_q    <= d_rdata_d;
            i_ready_q    <= i_ready_d;
            d_ready_q    <= d_ready_d;
            busy_q       <= busy_d;
        end
    end

    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign i_ready   = i_ready_q;
    assign d_ready   = d_ready_q;
    assign busy      = busy_q;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single main-memory port between the I-cache miss path and the D-cache miss/write-back path of the five-stage pipeline.
- Serializes line transactions through a 4-state FSM.
- Uses D-side fixed priority with a starvation limit that guarantees instruction fetch progress.
- All outputs are registered. The caches' stall logic (memory_stall into ID/EX) is derived from the ready pulses produced here.

Parameters:
ADDR_W  28  line address width (word address >> 2)
DATA_W  128  cache line width in bits
STARVE_LIMIT  4  max consecutive D grants while an I request waits (legal range 1..15)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous reset, active-high
i_read  input  1  I-cache line read request, held until i_ready
i_addr  input  ADDR_W  I-cache line address, stable while i_read high
i_rdata  output  DATA_W  line data, valid when i_ready=1
i_ready  output  1  one-cycle completion pulse to I-cache
d_read  input  1  D-cache line read request, held until d_ready
d_write  input  1  D-cache line write-back request, held until d_ready
d_addr  input  ADDR_W  D-cache line address, stable while request high
d_wdata  input  DATA_W  write-back line data
d_rdata  output  DATA_W  line data, valid when d_ready=1
d_ready  output  1  one-cycle completion pulse to D-cache
mem_read  output  1  memory read command, held until mem_ready
mem_write  output  1  memory write command, held until mem_ready
mem_addr  output  ADDR_W  memory line address
mem_wdata  output  DATA_W  memory write data
mem_rdata  input  DATA_W  memory read data, valid with mem_ready
mem_ready  input  1  one-cycle memory completion pulse
busy  output  1  high in any state other than IDLE

Behaviour:

Reset (rst=1 at edge):
- state=IDLE, starve_cnt=0.
- All outputs 0, including i_rdata/d_rdata.
- Reset in mid-transaction drops mem_read/mem_write on that edge. Any later mem_ready is ignored in IDLE.

FSM states: IDLE, SERVE_I, SERVE_D, RESP.

IDLE arbitration, evaluated each cycle:
- If (d_read|d_write) and not (i_read and starve_cnt==STARVE_LIMIT): go to SERVE_D.
  - Load mem_addr=d_addr.
  - If d_write: mem_write=1, mem_wdata=d_wdata. d_write wins if d_read and d_write are both high (illegal combination, defined anyway).
  - Else: mem_read=1.
  - starve_cnt increments if i_read=1, else clears.
- Else if i_read: go to SERVE_I, mem_read=1, mem_addr=i_addr, starve_cnt clears.
- Else: stay in IDLE.
- Request-to-command latency is 1 cycle.

SERVE_x:
- Hold command, address and data stable until mem_ready=1.
- On the mem_ready edge:
  - Clear mem_read/mem_write.
  - Capture mem_rdata into x_rdata (reads only; writes leave it unchanged).
  - Pulse x_ready=1 for exactly one cycle.
  - Go to RESP.
- Request inputs are not re-sampled while in SERVE_x.

RESP (1 cycle):
- x_ready is 1 during this cycle only.
- Requests are ignored, because the just-served requester is still dropping its request.
- Next state is IDLE.
- Minimum gap between memory commands: mem_ready edge → RESP → IDLE → new command, i.e. 2 idle cycles.

Output persistence:
- i_rdata/d_rdata keep their last value after the pulse.
- i_ready and d_ready are never high together.
- mem_read and mem_write are never high together.

Starvation:
- With both sides continuously requesting, the grant pattern is STARVE_LIMIT D grants, then 1 I grant, repeating.

Width:
- starve_cnt is 4 bits and saturates at STARVE_LIMIT.

busy:
- busy = (state != IDLE), registered with the state.

Test Plan:
- Lone I read, i_addr=28'h0000040; mem_ready arrives 3 cycles after mem_read with mem_rdata=128'hDEAD…BEEF → mem_read high 1 cycle after i_read, i_ready pulses exactly 1 cycle with i_rdata=DEAD…BEEF, d_ready stays 0.
- i_read and d_write rise together, d_addr=28'h0000100, d_wdata=128'h1234 → D write serviced first (mem_write=1, mem_addr=100), then I read. i_ready follows d_ready by ≥3 cycles plus memory latency.
- Continuous d_read and i_read, STARVE_LIMIT=4 → grant sequence D,D,D,D,I,D,D,D,D,I; starve_cnt returns to 0 after each I grant.
- rst=1 for 1 cycle while in SERVE_D with mem_read=1 → next cycle mem_read=0, busy=0, all ready=0. A mem_ready pulse 2 cycles later produces no d_ready, and the FSM stays in IDLE.
- D write-back to 28'h0000200 followed immediately by a D read of 28'h0000300 (cache re-asserts d_read the cycle after d_ready) → two separate transactions with a ≥2-cycle gap; d_rdata updated only by the read.
- d_read and d_write both high with d_addr=28'h0000010 → mem_write=1, mem_read=0; d_rdata unchanged after d_ready.
